// File: rtl/aes_ctr_reg.sv
// aes_ctr_reg: AES CTR counter storage with slice port for the increment FSM and req/ack front-end.
// Optional BUSY-state watchdog enabled by defining AES_CTR_REG_WATCHDOG_EN.
module aes_ctr_reg #(
   parameter int CtrWidth = 128,
   parameter int SliceSize = 16,
   localparam int NumSlices = CtrWidth / SliceSize,
   localparam int SliceIdxWidth = $clog2(NumSlices)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     load_i,
   input  logic [CtrWidth-1:0]      load_data_i,
   input  logic                     req_i,
   output logic                     ack_o,
   output logic [CtrWidth-1:0]      ctr_o,
   output logic                     incr_o,
   input  logic                     ready_i,
   input  logic [SliceIdxWidth-1:0] ctr_slice_idx_i,
   output logic [SliceSize-1:0]     ctr_slice_o,
   input  logic [SliceSize-1:0]     ctr_slice_i,
   input  logic                     ctr_we_i,
   output logic                     err_o
);
   localparam int CntW = $clog2(NumSlices + 1);
   localparam logic [CntW-1:0] Full = CntW'(NumSlices);

   typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_e;

   state_e state_q, state_d;
   logic [CtrWidth-1:0] ctr_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic ld, wr;
`ifdef AES_CTR_REG_WATCHDOG_EN
   logic [5:0] wd_q;
   logic timeout;
   assign timeout = wd_q == 6'(2 * NumSlices + 4);
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) wd_q <= '0;
      else wd_q <= (state_q == BUSY) ? wd_q + 6'd1 : '0;
`else
   logic timeout;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      ld = 1'b0;
      wr = 1'b0;
      incr_o = 1'b0;
      ack_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (ctr_we_i) state_d = ERROR;
            else if (load_i) ld = 1'b1;
            else if (req_i && ready_i) begin
               incr_o = 1'b1;
               cnt_d = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (load_i || (ctr_we_i && cnt_q == Full)) state_d = ERROR;
            else if (ready_i) begin
               ack_o = cnt_q == Full;
               state_d = (cnt_q == Full) ? IDLE : ERROR;
            end else if (timeout) state_d = ERROR;
            else if (ctr_we_i) begin
               wr = 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ERROR;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q <= '0;
         ctr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         if (ld) ctr_q <= load_data_i;
         else if (wr) ctr_q[SliceSize*ctr_slice_idx_i +: SliceSize] <= ctr_slice_i;
      end

   assign ctr_o = ctr_q;
   assign ctr_slice_o = ctr_q[SliceSize*ctr_slice_idx_i +: SliceSize];
   assign err_o = state_q == ERROR;
endmodule

// File: tb/tb_aes_ctr_reg.sv
// tb_aes_ctr_reg: directed vector bench for aes_ctr_reg with a behavioural ripple-carry counter FSM.
// Watchdog expectations follow AES_CTR_REG_WATCHDOG_EN.
module tb_aes_ctr_reg;
   logic clk = 1'b0, rst = 1'b1;
   logic load = 1'b0, req = 1'b0, ready = 1'b1, we = 1'b0;
   logic [127:0] load_data = '0;
   logic [2:0] idx = '0;
   logic [15:0] slice_in = '0;
   logic ack_o, incr_o, err_o;
   logic [127:0] ctr_o;
   logic [15:0] ctr_slice_o;
   int checks = 0, errors = 0;

   aes_ctr_reg dut (
      .clk_i(clk), .rst_i(rst), .load_i(load), .load_data_i(load_data),
      .req_i(req), .ack_o(ack_o), .ctr_o(ctr_o), .incr_o(incr_o),
      .ready_i(ready), .ctr_slice_idx_i(idx), .ctr_slice_o(ctr_slice_o),
      .ctr_slice_i(slice_in), .ctr_we_i(we), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] ld;
      logic [127:0] exp;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [127:0] v);
      @(negedge clk);
      load = 1'b1;
      load_data = v;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      req = 1'b0;
      we = 1'b0;
      load = 1'b0;
      ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("rst ctr_o", ctr_o, 0);
      chk("rst slice", 128'(ctr_slice_o), 0);
      chk("rst flags", {125'd0, ack_o, incr_o, err_o}, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drives one request and n ripple-carry slice writes, then raises ready.
   task automatic run_req(input int n, output logic ack);
      logic [15:0] s;
      logic c;
      @(negedge clk);
      req = 1'b1;
      ready = 1'b1;
      #1 chk("incr_o", 128'(incr_o), 1);
      @(negedge clk);
      ready = 1'b0;
      c = 1'b1;
      for (int k = 0; k < n; k++) begin
         idx = 3'(k);
         #1 s = ctr_slice_o;
         slice_in = s + 16'(c);
         c = c & (s == 16'hFFFF);
         we = 1'b1;
         @(negedge clk);
      end
      we = 1'b0;
      ready = 1'b1;
      #1 ack = ack_o;
      @(negedge clk);
      req = 1'b0;
   endtask

   initial begin
      logic a;
      vecs[0] = '{128'h0000_0000_0000_0000_0000_0000_0000_00FF, 128'h0000_0000_0000_0000_0000_0000_0000_0100};
      vecs[1] = '{{128{1'b1}}, 128'h0};
      vecs[2] = '{128'h0, 128'h1};
      vecs[3] = '{128'h0000_0000_0000_0000_0000_FFFF_FFFF_FFFF, 128'h0000_0000_0000_0000_0001_0000_0000_0000};
      vecs[4] = '{128'h1234_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1234_0000_0000_0001_0000_0000_0000_0000};
      #12;
      do_reset();

      for (int i = 0; i < 5; i++) begin
         do_load(vecs[i].ld);
         #1 chk("load", ctr_o, vecs[i].ld);
         run_req(8, a);
         chk("ack", 128'(a), 1);
         #1;
         chk("ack one cycle", 128'(ack_o), 0);
         chk("ctr_o", ctr_o, vecs[i].exp);
         chk("err_o", 128'(err_o), 0);
      end

      do_load(128'h0007_0006_0005_0004_0003_0002_0001_0000);
      for (int k = 0; k < 8; k++) begin
         idx = 3'(k);
         #1 chk("slice read", 128'(ctr_slice_o), 128'(k));
      end

      do_load(128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222);
      @(negedge clk);
      idx = 3'd2;
      slice_in = 16'hABCD;
      we = 1'b1;
      @(negedge clk);
      we = 1'b0;
      #1;
      chk("we in idle err", 128'(err_o), 1);
      chk("we in idle ctr", ctr_o, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222);
      do_reset();

      do_load(128'h0);
      run_req(5, a);
      #1;
      chk("short ack", 128'(a), 0);
      chk("short err", 128'(err_o), 1);
      do_reset();

      do_load(128'h55);
      @(negedge clk);
      req = 1'b1;
      #1 chk("incr_o", 128'(incr_o), 1);
      @(negedge clk);
      ready = 1'b0;
      load = 1'b1;
      load_data = 128'h99;
      @(negedge clk);
      load = 1'b0;
      req = 1'b0;
      ready = 1'b1;
      #1;
      chk("busy load err", 128'(err_o), 1);
      chk("busy load ctr", ctr_o, 128'h55);
      do_reset();

      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         idx = 3'(k);
         slice_in = 16'h1234;
         we = 1'b1;
         @(negedge clk);
      end
      do_reset();
      run_req(8, a);
      chk("post-rst ack", 128'(a), 1);
      #1;
      chk("post-rst ctr", ctr_o, 128'h1);
      chk("post-rst err", 128'(err_o), 0);

      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      req = 1'b0;
      repeat (25) @(negedge clk);
      #1;
`ifdef AES_CTR_REG_WATCHDOG_EN
      chk("watchdog err", 128'(err_o), 1);
`else
      chk("no watchdog err", 128'(err_o), 0);
`endif
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
